jtpopeye_objshift: RTL

Parametrised multi-channel object pixel shifter: the successor to the single-channel, two-plane object shifter in the video path. Each channel is double-buffered: one active shift register plus one pending slot. Channels accept row words through a valid/ready handshake and serialise them one pixel per `pxl_cen`, with optional horizontal flip. A fixed-priority mixer merges all channels into one registered object pixel for the colour mixer.

---
 rtl/jtpopeye_obj_pkg.sv | 35 +++
 rtl/jtpopeye_objshift_ch.sv | 97 +++++++++
 rtl/jtpopeye_objshift.sv | 94 +++++++++
 3 files changed

// File: rtl/jtpopeye_obj_pkg.sv
// Shared channel-state type and helpers for the multi-channel object shifter.
// Fields are sized for the largest supported configuration; unused upper bits stay zero.
package jtpopeye_obj_pkg;

  localparam int MAX_PLANES = 8;
  localparam int MAX_W      = 32;
  localparam int MAX_PALW   = 8;
  localparam int MAX_CNTW   = $clog2(MAX_W) + 1;

  typedef struct packed {
    logic [MAX_PLANES-1:0][MAX_W-1:0] planes;
    logic [MAX_PALW-1:0]              pal;
    logic                             hflip;
    logic [MAX_CNTW-1:0]              cnt;
  } obj_state_t;

  function automatic logic obj_transparent(
    input logic [MAX_PLANES-1:0] bits,
    input logic [MAX_PALW-1:0]   pal,
    input logic [MAX_CNTW-1:0]   cnt
  );
    return (bits == '0) || (pal == '0) || (cnt == '0);
  endfunction

  function automatic logic [MAX_W-1:0] low_mask(input int n);
    logic [MAX_W-1:0] m;
    for (int i = 0; i < MAX_W; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/jtpopeye_objshift_ch.sv
// One object channel: pending slot fed by a valid/ready handshake, plus the
// active shift register that serialises one pixel per pixel enable.
module jtpopeye_objshift_ch
  import jtpopeye_obj_pkg::*;
#(
  parameter int PLANES = 2,
  parameter int W      = 16,
  parameter int PALW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_pxl_cen,
  input  logic                 i_blank,
  input  logic                 i_ld_valid,
  output logic                 o_ld_ready,
  input  logic [PLANES*W-1:0]  i_ld_data,
  input  logic [PALW-1:0]      i_ld_pal,
  input  logic                 i_ld_hflip,
  output logic [PLANES-1:0]    o_bits,
  output logic [PALW-1:0]      o_pal,
  output logic                 o_opaque
);

  localparam logic [MAX_CNTW-1:0] CNT_FULL = MAX_CNTW'(W);
  localparam logic [MAX_CNTW-1:0] CNT_ONE  = MAX_CNTW'(1);
  localparam logic [MAX_W-1:0]    W_MASK   = low_mask(W);

  obj_state_t            r_act;
  obj_state_t            r_pend;
  logic                  r_pend_full;
  obj_state_t            w_ld;
  obj_state_t            w_shift;
  logic [MAX_PLANES-1:0] w_pix;
  logic                  w_accept;
  logic                  w_promote;

  // The pending copy already carries cnt=W so a promote is a plain struct copy.
  always_comb begin
    w_ld = '0;
    for (int p = 0; p < PLANES; p++) begin
      w_ld.planes[p] = MAX_W'(i_ld_data[p*W +: W]);
    end
    w_ld.pal   = MAX_PALW'(i_ld_pal);
    w_ld.hflip = i_ld_hflip;
    w_ld.cnt   = CNT_FULL;
  end

  always_comb begin
    w_pix = '0;
    for (int p = 0; p < PLANES; p++) begin
      w_pix[p] = r_act.hflip ? r_act.planes[p][W-1] : r_act.planes[p][0];
    end
  end

  // Left shifts are masked so stale bits never reach the flipped output bit.
  always_comb begin
    w_shift = r_act;
    for (int p = 0; p < MAX_PLANES; p++) begin
      w_shift.planes[p] = r_act.hflip ? ((r_act.planes[p] << 1) & W_MASK)
                                      : (r_act.planes[p] >> 1);
    end
    w_shift.cnt = r_act.cnt - CNT_ONE;
  end

  assign w_accept  = i_ld_valid & ~r_pend_full;
  assign w_promote = r_pend_full & (r_act.cnt <= CNT_ONE);

  // Accept and promote are mutually exclusive: one needs pending empty, the other full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act       <= '0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (i_pxl_cen) begin
        if (i_blank) begin
          r_act.cnt <= '0;
        end else if (w_promote) begin
          r_act       <= r_pend;
          r_pend_full <= 1'b0;
        end else if (r_act.cnt != '0) begin
          r_act <= w_shift;
        end
      end
      if (w_accept) begin
        r_pend      <= w_ld;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign o_ld_ready = ~r_pend_full;
  assign o_bits     = w_pix[PLANES-1:0];
  assign o_pal      = r_act.pal[PALW-1:0];
  assign o_opaque   = ~obj_transparent(w_pix, r_act.pal, r_act.cnt);

endmodule

// File: rtl/jtpopeye_objshift.sv
// Multi-channel object pixel shifter: CH double-buffered channels merged by a
// fixed-priority mixer (lowest index wins) into one registered object pixel.
module jtpopeye_objshift
  import jtpopeye_obj_pkg::*;
#(
  parameter int CH     = 2,
  parameter int PLANES = 2,
  parameter int W      = 16,
  parameter int PALW   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pxl_cen,
  input  logic                       blank,
  input  logic [CH-1:0]              ld_valid,
  output logic [CH-1:0]              ld_ready,
  input  logic [CH*PLANES*W-1:0]     ld_data,
  input  logic [CH*PALW-1:0]         ld_pal,
  input  logic [CH-1:0]              ld_hflip,
  output logic [PALW+PLANES-1:0]     pxl_col,
  output logic [ch_idx_w(CH)-1:0]    pxl_ch,
  output logic                       pxl_valid
);

  localparam int CHW = ch_idx_w(CH);

  logic [CH-1:0][PLANES-1:0] w_bits;
  logic [CH-1:0][PALW-1:0]   w_pal;
  logic [CH-1:0]             w_opaque;
  logic [PALW+PLANES-1:0]    w_col;
  logic [CHW-1:0]            w_ch;
  logic                      w_hit;
  logic [PALW+PLANES-1:0]    r_col;
  logic [CHW-1:0]            r_ch;
  logic                      r_valid;

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    jtpopeye_objshift_ch #(
      .PLANES (PLANES),
      .W      (W),
      .PALW   (PALW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_pxl_cen  (pxl_cen),
      .i_blank    (blank),
      .i_ld_valid (ld_valid[gi]),
      .o_ld_ready (ld_ready[gi]),
      .i_ld_data  (ld_data[gi*PLANES*W +: PLANES*W]),
      .i_ld_pal   (ld_pal[gi*PALW +: PALW]),
      .i_ld_hflip (ld_hflip[gi]),
      .o_bits     (w_bits[gi]),
      .o_pal      (w_pal[gi]),
      .o_opaque   (w_opaque[gi])
    );
  end

  // Scan from the highest index down so the lowest opaque channel is written last.
  always_comb begin
    w_col = '0;
    w_ch  = '0;
    w_hit = 1'b0;
    for (int c = CH - 1; c >= 0; c--) begin
      if (w_opaque[c]) begin
        w_col = {w_pal[c], w_bits[c]};
        w_ch  = CHW'(c);
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
    end else if (pxl_cen) begin
      if (blank) begin
        r_col   <= '0;
        r_ch    <= '0;
        r_valid <= 1'b0;
      end else begin
        r_col   <= w_col;
        r_ch    <= w_ch;
        r_valid <= w_hit;
      end
    end
  end

  assign pxl_col   = r_col;
  assign pxl_ch    = r_ch;
  assign pxl_valid = r_valid;

endmodule
